// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer:
// state encodings, cause codes, request priority.
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT = 2'd0,
      ST_PERIPH = 2'd1,
      ST_HOLD   = 2'd2,
      ST_RUN    = 2'd3
   } state_t;

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_WDOG = 2'b01;
   localparam logic [1:0] CAUSE_BTN  = 2'b10;
   localparam logic [1:0] CAUSE_SW   = 2'b11;

   // Highest-priority request wins: wdog > btn > sw.
   function automatic logic [1:0] req_cause(
      input logic w,
      input logic b,
      input logic s
   );
      if (w)      return CAUSE_WDOG;
      else if (b) return CAUSE_BTN;
      else if (s) return CAUSE_SW;
      else        return CAUSE_POR;
   endfunction

endpackage

// File: rtl/rstseq_timer.sv
// Delay counter shared by the ASSERT and PERIPH phases.
// Counts while enabled, clears on request, flags terminal count.
module rstseq_timer #(
   parameter int unsigned CW = 8
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          clr,
   input  logic          en,
   input  logic [CW-1:0] tc_val,
   output logic          tc
);

   logic [CW-1:0] cnt;

   // Up-counter; clear wins over enable so it never wraps.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tc = (cnt == tc_val);

endmodule

// File: rtl/reset_sequencer.sv
// Merges reset requests and releases peripherals, then CPU,
// in order; records the cause and number of resets.
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned CW            = 8,
   parameter int unsigned ASSERT_CYCLES = 16,
   parameter int unsigned CPU_DLY       = 64
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req_wdog,
   input  logic       req_btn,
   input  logic       req_sw,
   input  logic       hold_cpu,
   output logic       periph_rstn,
   output logic       cpu_rstn,
   output logic       busy,
   output logic [1:0] last_cause,
   output logic [7:0] reset_count
);

   localparam logic [CW-1:0] A_TC = CW'(ASSERT_CYCLES - 1);
   localparam logic [CW-1:0] P_TC = CW'(CPU_DLY - 1);

   state_t        state;
   logic          req_any;
   logic [1:0]    cause;
   logic          tc;
   logic          clr;
   logic          en;
   logic [CW-1:0] tc_val;

   assign req_any = req_wdog | req_btn | req_sw;
   assign cause   = req_cause(req_wdog, req_btn, req_sw);
   assign tc_val  = (state == ST_PERIPH) ? P_TC : A_TC;
   assign busy    = (state != ST_RUN);

   // Timer control: count in the timed phases, clear on
   // every state change and while a request is present.
   always_comb begin
      en  = 1'b0;
      clr = req_any;
      unique case (state)
         ST_ASSERT: begin
            en  = 1'b1;
            clr = req_any | tc;
         end
         ST_PERIPH: begin
            en  = 1'b1;
            clr = req_any | tc;
         end
         ST_HOLD: begin
            clr = req_any | ~hold_cpu;
         end
         ST_RUN: begin
            clr = req_any;
         end
      endcase
   end

   rstseq_timer #(
      .CW(CW)
   ) u_timer (
      .clk   (clk),
      .resetn(resetn),
      .clr   (clr),
      .en    (en),
      .tc_val(tc_val),
      .tc    (tc)
   );

   // Sequencer FSM with registered reset outputs;
   // a request overrides every transition.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_ASSERT;
         periph_rstn <= 1'b0;
         cpu_rstn    <= 1'b0;
         last_cause  <= CAUSE_POR;
         reset_count <= 8'd0;
      end else if (req_any) begin
         state       <= ST_ASSERT;
         periph_rstn <= 1'b0;
         cpu_rstn    <= 1'b0;
         last_cause  <= cause;
         if (state != ST_ASSERT && reset_count != 8'hFF) begin
            reset_count <= reset_count + 8'd1;
         end
      end else begin
         unique case (state)
            ST_ASSERT: begin
               if (tc) begin
                  state       <= ST_PERIPH;
                  periph_rstn <= 1'b1;
               end
            end
            ST_PERIPH: begin
               if (tc) begin
                  if (!hold_cpu) begin
                     state    <= ST_RUN;
                     cpu_rstn <= 1'b1;
                  end else begin
                     state <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!hold_cpu) begin
                  state    <= ST_RUN;
                  cpu_rstn <= 1'b1;
               end
            end
            ST_RUN: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed vector bench for reset_sequencer
// with ASSERT_CYCLES=4, CPU_DLY=6.
module tb_reset_sequencer;

   logic       clk;
   logic       resetn;
   logic       req_wdog;
   logic       req_btn;
   logic       req_sw;
   logic       hold_cpu;
   logic       periph_rstn;
   logic       cpu_rstn;
   logic       busy;
   logic [1:0] last_cause;
   logic [7:0] reset_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       w;
      logic       b;
      logic       s;
      logic       h;
      logic       p;
      logic       c;
      logic       bz;
      logic [1:0] ca;
      logic [7:0] cn;
   } vec_t;

   vec_t vq[$];

   reset_sequencer #(
      .CW(8),
      .ASSERT_CYCLES(4),
      .CPU_DLY(6)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_wdog   (req_wdog),
      .req_btn    (req_btn),
      .req_sw     (req_sw),
      .hold_cpu   (hold_cpu),
      .periph_rstn(periph_rstn),
      .cpu_rstn   (cpu_rstn),
      .busy       (busy),
      .last_cause (last_cause),
      .reset_count(reset_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input int n,
                               input logic w, input logic b,
                               input logic s, input logic h,
                               input logic p, input logic c,
                               input logic bz,
                               input logic [1:0] ca,
                               input logic [7:0] cn);
      vec_t v;
      v.w = w; v.b = b; v.s = s; v.h = h;
      v.p = p; v.c = c; v.bz = bz; v.ca = ca; v.cn = cn;
      for (int k = 0; k < n; k++) vq.push_back(v);
   endfunction

   // Idle release: 3 edges held, periph up at 4th,
   // cpu up 6 edges later.
   function automatic void rel(input logic [1:0] ca,
                               input logic [7:0] cn);
      add(3, 0, 0, 0, 0, 0, 0, 1, ca, cn);
      add(6, 0, 0, 0, 0, 1, 0, 1, ca, cn);
      add(1, 0, 0, 0, 0, 1, 1, 0, ca, cn);
   endfunction

   initial begin
      resetn   = 1'b1;
      req_wdog = 1'b0;
      req_btn  = 1'b0;
      req_sw   = 1'b0;
      hold_cpu = 1'b0;

      // power-on release, then idle in RUN
      rel(2'd0, 8'd0);
      add(2, 0, 0, 0, 0, 1, 1, 0, 2'd0, 8'd0);
      // one-cycle button pulse from RUN
      add(1, 0, 1, 0, 0, 0, 0, 1, 2'd2, 8'd1);
      rel(2'd2, 8'd1);
      // simultaneous wdog + sw
      add(1, 1, 0, 1, 0, 0, 0, 1, 2'd1, 8'd2);
      rel(2'd1, 8'd2);
      // sw held for 10 cycles
      add(10, 0, 0, 1, 0, 0, 0, 1, 2'd3, 8'd3);
      rel(2'd3, 8'd3);
      // hold_cpu parks in HOLD, then releases
      add(1, 0, 1, 0, 1, 0, 0, 1, 2'd2, 8'd4);
      add(3, 0, 0, 0, 1, 0, 0, 1, 2'd2, 8'd4);
      add(6, 0, 0, 0, 1, 1, 0, 1, 2'd2, 8'd4);
      add(15, 0, 0, 0, 1, 1, 0, 1, 2'd2, 8'd4);
      add(1, 0, 0, 0, 0, 1, 1, 0, 2'd2, 8'd4);
      add(2, 0, 0, 0, 1, 1, 1, 0, 2'd2, 8'd4);
      // button during PERIPH restarts and counts
      add(1, 0, 1, 0, 0, 0, 0, 1, 2'd2, 8'd5);
      add(3, 0, 0, 0, 0, 0, 0, 1, 2'd2, 8'd5);
      add(2, 0, 0, 0, 0, 1, 0, 1, 2'd2, 8'd5);
      add(1, 0, 1, 0, 0, 0, 0, 1, 2'd2, 8'd6);
      rel(2'd2, 8'd6);

      // asynchronous reset state
      #2 resetn = 1'b0;
      #1;
      chk("rst periph", periph_rstn, 0);
      chk("rst cpu", cpu_rstn, 0);
      chk("rst busy", busy, 1);
      chk("rst cause", last_cause, 0);
      chk("rst count", reset_count, 0);
      step();
      step();
      @(negedge clk);
      resetn = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         req_wdog = vq[i].w;
         req_btn  = vq[i].b;
         req_sw   = vq[i].s;
         hold_cpu = vq[i].h;
         step();
         chk($sformatf("row%0d periph", i), periph_rstn, vq[i].p);
         chk($sformatf("row%0d cpu", i), cpu_rstn, vq[i].c);
         chk($sformatf("row%0d busy", i), busy, vq[i].bz);
         chk($sformatf("row%0d cause", i), last_cause, vq[i].ca);
         chk($sformatf("row%0d count", i), reset_count, vq[i].cn);
      end
      req_wdog = 1'b0;
      req_btn  = 1'b0;
      req_sw   = 1'b0;
      hold_cpu = 1'b0;

      // resetn pulsed low while in PERIPH
      req_btn = 1'b1;
      step();
      req_btn = 1'b0;
      repeat (5) step();
      chk("pre periph", periph_rstn, 1);
      chk("pre cpu", cpu_rstn, 0);
      chk("pre count", reset_count, 7);
      #2 resetn = 1'b0;
      #1;
      chk("async periph", periph_rstn, 0);
      chk("async cpu", cpu_rstn, 0);
      chk("async busy", busy, 1);
      chk("async cause", last_cause, 0);
      chk("async count", reset_count, 0);
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) step();
      chk("por2 periph e3", periph_rstn, 0);
      step();
      chk("por2 periph e4", periph_rstn, 1);
      repeat (5) step();
      chk("por2 cpu e9", cpu_rstn, 0);
      step();
      chk("por2 cpu e10", cpu_rstn, 1);
      chk("por2 busy e10", busy, 0);

      // 300 counted requests saturate the counter
      for (int i = 0; i < 300; i++) begin
         req_wdog = 1'b1;
         step();
         req_wdog = 1'b0;
         repeat (4) step();
         if (i == 253) chk("count 254", reset_count, 254);
      end
      chk("count sat", reset_count, 255);
      chk("sat cause", last_cause, 1);

      begin
         int n;
         n = 0;
         while (busy && n < 50) begin
            step();
            n++;
         end
         chk("final run busy", busy, 0);
         chk("final cpu", cpu_rstn, 1);
         chk("final count", reset_count, 255);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
